ternary_sa_stream: RTL and testbench



---
 rtl/ternary_pkg.sv | 28 ++
 rtl/ternary_sa_stage.sv | 50 +++++
 rtl/ternary_sa_stream.sv | 150 +++++++++++++++
 tb/tb_ternary_sa_stream.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared ternary weight codes, FSM states and the multiply-free MAC helper.
package ternary_pkg;

  typedef logic [1:0] tw_t;

  localparam tw_t TW_ZERO = 2'b00;
  localparam tw_t TW_POS  = 2'b01;
  localparam tw_t TW_NEG  = 2'b11;
  localparam tw_t TW_BAD  = 2'b10;

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} sa_state_t;

  // Wide enough for any legal ACC_W; callers sign-extend in and truncate out.
  localparam int MAC_W = 64;
  typedef logic signed [MAC_W-1:0] mac_t;

  function automatic mac_t tern_mac(input mac_t acc, input mac_t x, input tw_t w);
    mac_t res;
    res = acc;
    case (w)
      TW_POS:  res = acc + x;
      TW_NEG:  res = acc - x;
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ternary_sa_stage.sv
// One pipeline stage: adds +/-x[K] (or nothing) into each of ROWS partial sums.
// Registers the x vector, the sums and a valid bit; shifts only when adv is high.
module ternary_sa_stage
  import ternary_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KDIM  = 8,
  parameter int ROWS  = 4,
  parameter int ACC_W = 20,
  parameter int K     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    prev_vld,
  input  logic [KDIM*WIDTH-1:0]   prev_x,
  input  logic [ROWS*ACC_W-1:0]   prev_psum,
  input  logic [2*ROWS-1:0]       codes,
  output logic                    vld,
  output logic [KDIM*WIDTH-1:0]   x,
  output logic [ROWS*ACC_W-1:0]   psum
);

  logic [ROWS*ACC_W-1:0]    psum_nxt;
  logic [MAC_W-ACC_W-1:0]   mac_unused_hi;

  always_comb begin
    psum_nxt      = '0;
    mac_unused_hi = '0;
    for (int r = 0; r < ROWS; r++) begin
      {mac_unused_hi, psum_nxt[r*ACC_W +: ACC_W]} =
        tern_mac(MAC_W'($signed(prev_psum[r*ACC_W +: ACC_W])),
                 MAC_W'($signed(prev_x[K*WIDTH +: WIDTH])),
                 tw_t'(codes[2*r +: 2]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      x    <= '0;
      psum <= '0;
    end else if (adv) begin
      vld  <= prev_vld;
      x    <= prev_x;
      psum <= psum_nxt;
    end
  end

endmodule

// File: rtl/ternary_sa_stream.sv
// Streaming ternary y = W*x engine with double-buffered weights; latency KDIM, one vector/cycle.
// Whole pipeline stalls while y_valid && !y_ready; commits drain the pipe before the bank swap.
module ternary_sa_stream
  import ternary_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int KDIM  = 8,
  parameter  int ROWS  = 4,
  localparam int ACC_W = WIDTH + $clog2(KDIM) + 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [RW-1:0]           w_row,
  input  logic [2*KDIM-1:0]       w_data,
  input  logic                    w_commit,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [KDIM*WIDTH-1:0]   x_data,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [ROWS*ACC_W-1:0]   y_data,
  output logic                    busy,
  output logic                    w_err
);

  localparam int XW    = KDIM * WIDTH;
  localparam int YW    = ROWS * ACC_W;
  // Input register plus KDIM MAC stages can hold KDIM+1 vectors.
  localparam int OCC_W = $clog2(KDIM + 2);

  tw_t              bank [2][ROWS][KDIM];
  logic             bank_sel;
  sa_state_t        state, state_nxt;
  logic [OCC_W-1:0] occ;
  logic             adv, accept, pop;

  logic             in_vld;
  logic [XW-1:0]    in_x;
  logic             s_vld  [KDIM];
  logic [XW-1:0]    s_x    [KDIM];
  logic [YW-1:0]    s_psum [KDIM];
  logic [2*ROWS-1:0] col_codes [KDIM];

  logic [2*KDIM-1:0] w_clean;
  logic              w_bad;
  logic              unused_tail;

  assign adv         = !y_valid || y_ready;
  assign accept      = x_valid && x_ready;
  assign pop         = y_valid && y_ready;
  assign y_valid     = s_vld[KDIM-1];
  assign y_data      = s_psum[KDIM-1];
  assign busy        = (occ != '0) || (state != RUN);
  assign unused_tail = ^s_x[KDIM-1];

  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    w_ready   = 1'b0;
    case (state)
      RUN: begin
        x_ready = adv;
        w_ready = 1'b1;
        if (w_commit) state_nxt = DRAIN;
      end
      DRAIN:   if (occ == '0) state_nxt = SWAP;
      SWAP:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Illegal codes are stored as zero and flagged.
  always_comb begin
    w_clean = '0;
    w_bad   = 1'b0;
    for (int k = 0; k < KDIM; k++) begin
      if (w_data[2*k +: 2] == TW_BAD) w_bad = 1'b1;
      else                            w_clean[2*k +: 2] = w_data[2*k +: 2];
    end
  end

  always_comb begin
    for (int k = 0; k < KDIM; k++) begin
      col_codes[k] = '0;
      for (int r = 0; r < ROWS; r++) col_codes[k][2*r +: 2] = bank[bank_sel][r][k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      bank_sel <= 1'b0;
      occ      <= '0;
      w_err    <= 1'b0;
      in_vld   <= 1'b0;
      in_x     <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < KDIM; k++) bank[b][r][k] <= TW_ZERO;
    end else begin
      state <= state_nxt;
      if (state == SWAP) bank_sel <= !bank_sel;
      if (adv) begin
        in_vld <= accept;
        in_x   <= x_data;
      end
      if (accept && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !accept) occ <= occ - OCC_W'(1);
      if (w_valid && w_ready) begin
        for (int k = 0; k < KDIM; k++) bank[!bank_sel][w_row][k] <= w_clean[2*k +: 2];
        if (w_bad) w_err <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < KDIM; k++) begin : g_stage
    logic          prev_vld;
    logic [XW-1:0] prev_x;
    logic [YW-1:0] prev_psum;

    if (k == 0) begin : g_first
      assign prev_vld  = in_vld;
      assign prev_x    = in_x;
      assign prev_psum = '0;
    end else begin : g_chain
      assign prev_vld  = s_vld[k-1];
      assign prev_x    = s_x[k-1];
      assign prev_psum = s_psum[k-1];
    end

    ternary_sa_stage #(
      .WIDTH(WIDTH), .KDIM(KDIM), .ROWS(ROWS), .ACC_W(ACC_W), .K(k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .prev_vld (prev_vld),
      .prev_x   (prev_x),
      .prev_psum(prev_psum),
      .codes    (col_codes[k]),
      .vld      (s_vld[k]),
      .x        (s_x[k]),
      .psum     (s_psum[k])
    );
  end

endmodule

// File: tb/tb_ternary_sa_stream.sv
// Directed bench for ternary_sa_stream: identity, full range, backpressure, swap, illegal code, reset.
module tb_ternary_sa_stream;

  localparam int WIDTH = 16;
  localparam int KDIM  = 8;
  localparam int ROWS  = 4;
  localparam int ACC_W = WIDTH + $clog2(KDIM) + 1;
  localparam int RW    = $clog2(ROWS);
  localparam int XW    = KDIM * WIDTH;
  localparam int YW    = ROWS * ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             w_valid = 1'b0, w_commit = 1'b0, x_valid = 1'b0, y_ready = 1'b0;
  logic             w_ready, x_ready, y_valid, busy, w_err;
  logic [RW-1:0]    w_row = '0;
  logic [2*KDIM-1:0] w_data = '0;
  logic [XW-1:0]    x_data = '0;
  logic [YW-1:0]    y_data;

  int     checks = 0;
  int     failures = 0;
  int     wa [ROWS][KDIM];
  int     ws [ROWS][KDIM];
  longint got [ROWS];
  logic [XW-1:0] xv;
  logic [XW-1:0] xs [3];
  logic [XW-1:0] xq [$];
  logic [YW-1:0] held;
  logic [2*KDIM-1:0] d;

  ternary_sa_stream #(.WIDTH(WIDTH), .KDIM(KDIM), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .w_data(w_data), .w_commit(w_commit),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .busy(busy), .w_err(w_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint yrow(input int r);
    return longint'($signed(y_data[r*ACC_W +: ACC_W]));
  endfunction

  function automatic int dec(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2*KDIM-1:0] rep(input logic [1:0] c);
    logic [2*KDIM-1:0] v;
    for (int k = 0; k < KDIM; k++) v[2*k +: 2] = c;
    return v;
  endfunction

  function automatic longint model(input int r, input logic [XW-1:0] x);
    longint s = 0;
    for (int k = 0; k < KDIM; k++)
      s += longint'(wa[r][k]) * longint'($signed(x[k*WIDTH +: WIDTH]));
    return s;
  endfunction

  function automatic void clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KDIM; k++) begin
        wa[r][k] = 0;
        ws[r][k] = 0;
      end
  endfunction

  function automatic void model_swap();
    int t;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KDIM; k++) begin
        t = wa[r][k];
        wa[r][k] = ws[r][k];
        ws[r][k] = t;
      end
  endfunction

  task automatic write_row(input int r, input logic [2*KDIM-1:0] dat);
    w_valid = 1'b1;
    w_row   = RW'(r);
    w_data  = dat;
    #1;
    chk("w_ready", w_ready, 1);
    tick();
    w_valid = 1'b0;
    for (int k = 0; k < KDIM; k++) ws[r][k] = dec(dat[2*k +: 2]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    #1;
    while (busy && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk(tag, busy, 0);
    tick();
  endtask

  task automatic commit_and_wait(input string tag);
    w_commit = 1'b1;
    tick();
    w_commit = 1'b0;
    wait_idle(tag);
    model_swap();
  endtask

  task automatic send_vec(input logic [XW-1:0] x, input string tag);
    int n = 0;
    x_data  = x;
    x_valid = 1'b1;
    y_ready = 1'b1;
    #1;
    while (!x_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk({tag, "_acc"}, x_ready, 1);
    tick();
    x_valid = 1'b0;
    n = 0;
    #1;
    while (!y_valid && n < 40) begin
      tick();
      #1;
      n++;
    end
    chk({tag, "_yv"}, y_valid, 1);
    for (int r = 0; r < ROWS; r++) got[r] = yrow(r);
    tick();
  endtask

  initial begin
    int early, low, got_n, sent, rcvd, stale;
    logic prev_stall;
    logic [XW-1:0] xcur;

    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data_zero", longint'(y_data === '0), 1);
    chk("rst_busy", busy, 0);
    chk("rst_w_err", w_err, 0);
    chk("rst_x_ready", x_ready, 1);
    chk("rst_w_ready", w_ready, 1);
    tick();

    // Identity weights; commit with empty pipe shows DRAIN, SWAP, RUN.
    for (int r = 0; r < ROWS; r++) begin
      d = '0;
      d[2*r +: 2] = 2'b01;
      write_row(r, d);
    end
    w_commit = 1'b1;
    tick();
    w_commit = 1'b0;
    #1;
    chk("cm_drain_busy", busy, 1);
    chk("cm_drain_xrdy", x_ready, 0);
    chk("cm_drain_wrdy", w_ready, 0);
    tick();
    #1;
    chk("cm_swap_busy", busy, 1);
    chk("cm_swap_xrdy", x_ready, 0);
    tick();
    #1;
    chk("cm_run_busy", busy, 0);
    chk("cm_run_xrdy", x_ready, 1);
    model_swap();
    xv = '0;
    xv[0*WIDTH +: WIDTH] = WIDTH'(3);
    xv[1*WIDTH +: WIDTH] = WIDTH'(-5);
    xv[2*WIDTH +: WIDTH] = WIDTH'(7);
    xv[3*WIDTH +: WIDTH] = WIDTH'(100);
    xv[4*WIDTH +: WIDTH] = WIDTH'(11);
    xv[5*WIDTH +: WIDTH] = WIDTH'(-22);
    xv[6*WIDTH +: WIDTH] = WIDTH'(33);
    xv[7*WIDTH +: WIDTH] = WIDTH'(-44);
    x_data  = xv;
    x_valid = 1'b1;
    y_ready = 1'b1;
    tick();
    x_valid = 1'b0;
    early = 0;
    for (int i = 0; i < KDIM; i++) begin
      #1;
      early += int'(y_valid);
      tick();
    end
    #1;
    chk("id_early_valid", early, 0);
    chk("id_latency", y_valid, 1);
    chk("id_y0", yrow(0), 3);
    chk("id_y1", yrow(1), -5);
    chk("id_y2", yrow(2), 7);
    chk("id_y3", yrow(3), 100);
    tick();

    // Full-range extremes.
    for (int r = 0; r < ROWS; r++) write_row(r, rep(2'b11));
    commit_and_wait("fr_neg_idle");
    for (int k = 0; k < KDIM; k++) xv[k*WIDTH +: WIDTH] = WIDTH'(-32768);
    send_vec(xv, "fr_neg");
    for (int r = 0; r < ROWS; r++) chk("fr_neg_y", got[r], 262144);
    for (int r = 0; r < ROWS; r++) write_row(r, rep(2'b01));
    commit_and_wait("fr_pos_idle");
    for (int k = 0; k < KDIM; k++) xv[k*WIDTH +: WIDTH] = WIDTH'(32767);
    send_vec(xv, "fr_pos");
    for (int r = 0; r < ROWS; r++) chk("fr_pos_y", got[r], 262136);

    // Random weights, 10 random vectors, random backpressure.
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < KDIM; k++) begin
        case ($urandom_range(0, 2))
          0:       d[2*k +: 2] = 2'b00;
          1:       d[2*k +: 2] = 2'b01;
          default: d[2*k +: 2] = 2'b11;
        endcase
      end
      write_row(r, d);
    end
    commit_and_wait("bp_idle");
    for (int k = 0; k < KDIM; k++) xcur[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
    sent = 0;
    rcvd = 0;
    prev_stall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400 && rcvd < 10; cyc++) begin
      x_valid = (sent < 10) && ($urandom_range(0, 3) != 0);
      x_data  = xcur;
      y_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) chk("bp_hold", longint'(y_data === held), 1);
      if (x_valid && x_ready) begin
        xq.push_back(xcur);
        sent++;
        for (int k = 0; k < KDIM; k++) xcur[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
      end
      if (y_valid && y_ready) begin
        chk("bp_not_extra", longint'(xq.size() != 0), 1);
        if (xq.size() != 0) begin
          for (int r = 0; r < ROWS; r++) chk("bp_y", yrow(r), model(r, xq[0]));
          void'(xq.pop_front());
        end
        rcvd++;
      end
      prev_stall = y_valid && !y_ready;
      held = y_data;
      tick();
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    chk("bp_count", rcvd, 10);
    #1;
    chk("bp_no_dup", y_valid, 0);
    tick();

    // Swap requested with three vectors in flight.
    for (int r = 0; r < ROWS; r++) write_row(r, rep(2'b01));
    commit_and_wait("sw_setup_idle");
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < KDIM; k++) xs[i][k*WIDTH +: WIDTH] = WIDTH'(100*i + 7*k - 20);
    y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_data  = xs[i];
      x_valid = 1'b1;
      #1;
      chk("sw_acc", x_ready, 1);
      tick();
    end
    x_valid = 1'b0;
    for (int r = 0; r < ROWS; r++) write_row(r, rep(2'b11));
    w_commit = 1'b1;
    tick();
    w_commit = 1'b0;
    low = 0;
    got_n = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (y_valid) begin
        if (got_n < 3)
          for (int r = 0; r < ROWS; r++) chk("sw_old_bank", yrow(r), model(r, xs[got_n]));
        got_n++;
      end
      if (x_ready) break;
      chk("sw_wrdy_low", w_ready, 0);
      low++;
      tick();
    end
    chk("sw_low_cycles", low, 6);
    chk("sw_drained", got_n, 3);
    model_swap();
    tick();
    send_vec(xs[0], "sw_new");
    for (int r = 0; r < ROWS; r++) chk("sw_neg_y", got[r], -36);

    // Illegal code 2'b10 in row 0, column 2.
    #1;
    chk("ill_pre", w_err, 0);
    d = rep(2'b01);
    d[5:4] = 2'b10;
    write_row(0, d);
    #1;
    chk("ill_rise", w_err, 1);
    commit_and_wait("ill_idle");
    for (int k = 0; k < KDIM; k++) xv[k*WIDTH +: WIDTH] = WIDTH'(1 << k);
    send_vec(xv, "ill");
    chk("ill_y0", got[0], 251);
    for (int r = 1; r < ROWS; r++) chk("ill_yr", got[r], 255);
    #1;
    chk("ill_sticky", w_err, 1);
    tick();

    // Reset with five vectors in flight and a pending swap.
    for (int r = 0; r < ROWS; r++) write_row(r, rep(2'b11));
    y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < KDIM; k++) x_data[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 999));
      x_valid = 1'b1;
      #1;
      chk("mr_acc", x_ready, 1);
      tick();
    end
    x_valid  = 1'b0;
    w_commit = 1'b1;
    tick();
    w_commit = 1'b0;
    #1;
    chk("mr_pre_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_model();
    #1;
    chk("mr_y_valid", y_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_y_data_zero", longint'(y_data === '0), 1);
    chk("mr_w_err", w_err, 0);
    chk("mr_x_ready", x_ready, 1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      #1;
      stale += int'(y_valid);
    end
    chk("mr_no_stale", stale, 0);
    tick();
    for (int r = 0; r < ROWS; r++) begin
      d = '0;
      d[2*r +: 2] = 2'b01;
      write_row(r, d);
    end
    for (int k = 0; k < KDIM; k++) xv[k*WIDTH +: WIDTH] = WIDTH'(10*k + 1);
    send_vec(xv, "mr_nocommit");
    for (int r = 0; r < ROWS; r++) chk("mr_nocommit_y", got[r], 0);
    commit_and_wait("mr_cm_idle");
    send_vec(xv, "mr_id");
    for (int r = 0; r < ROWS; r++) chk("mr_id_y", got[r], longint'(10*r + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
